// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: state codes and default tick derivation.
package stopwatch_pkg;

    localparam int unsigned STATE_W         = 2;
    localparam int unsigned CLK_FREQ_HZ_DEF = 100_000_000;
    localparam int unsigned TICK_HZ_DEF     = 100;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    function automatic int unsigned tick_div(input int unsigned clk_hz, input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic logic is_running(input state_t s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_tick_prescaler.sv
// Count-enable prescaler: divides clk by TICK_DIV while enabled, holds its phase otherwise.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    input  logic i_clr,
    input  logic i_hold,
    output logic o_tick_c
);

    localparam int unsigned P_W = $clog2(TICK_DIV);
    localparam logic [P_W-1:0] P_LAST = P_W'(TICK_DIV - 1);

    logic [P_W-1:0] r_p;
    logic           w_at_last;
    logic           w_adv;

    // A hold request still lets a due tick through so the terminal count is never lost.
    assign w_at_last = (r_p == P_LAST);
    assign w_adv     = i_en & (~i_hold | w_at_last);
    assign o_tick_c  = w_adv & w_at_last;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_p <= '0;
        end else if (w_adv) begin
            r_p <= w_at_last ? '0 : r_p + P_W'(1);
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: turns debounced button pulses into count/clear/lap/freeze controls.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = CLK_FREQ_HZ_DEF,
    parameter int unsigned TICK_HZ     = TICK_HZ_DEF,
    parameter int unsigned TICK_DIV    = tick_div(CLK_FREQ_HZ, TICK_HZ)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_btn_start_stop,
    input  logic               i_btn_lap_clear,
    input  logic               i_time_max,
    output logic               o_count_en,
    output logic               o_count_clr,
    output logic               o_lap_latch,
    output logic               o_disp_freeze,
    output logic               o_running,
    output logic [STATE_W-1:0] o_state
);

    state_t r_state;
    state_t w_next_state;
    logic   w_clr_c;
    logic   w_lap_c;
    logic   w_tick_c;
    logic   w_pre_en;
    logic   w_pre_clr;

    logic   r_count_en;
    logic   r_count_clr;
    logic   r_lap_latch;
    logic   r_disp_freeze;
    logic   r_running;

    assign w_pre_en  = is_running(r_state) & ~i_time_max;
    assign w_pre_clr = (r_state == ST_IDLE);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_en     (w_pre_en),
        .i_clr    (w_pre_clr),
        .i_hold   (i_btn_start_stop),
        .o_tick_c (w_tick_c)
    );

    // Start/stop always beats lap/clear; time_max forces a stop and locks out restart.
    always_comb begin
        w_next_state = r_state;
        w_clr_c      = 1'b0;
        w_lap_c      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_btn_start_stop)     w_next_state = ST_RUN;
                else if (i_btn_lap_clear) w_clr_c      = 1'b1;
            end
            ST_RUN: begin
                if (i_time_max || i_btn_start_stop) begin
                    w_next_state = ST_PAUSE;
                end else if (i_btn_lap_clear) begin
                    w_next_state = ST_LAP;
                    w_lap_c      = 1'b1;
                end
            end
            ST_LAP: begin
                if (i_time_max || i_btn_start_stop) w_next_state = ST_PAUSE;
                else if (i_btn_lap_clear)           w_next_state = ST_RUN;
            end
            ST_PAUSE: begin
                if (i_btn_start_stop && !i_time_max) begin
                    w_next_state = ST_RUN;
                end else if (i_btn_lap_clear) begin
                    w_next_state = ST_IDLE;
                    w_clr_c      = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_count_en    <= 1'b0;
            r_count_clr   <= 1'b0;
            r_lap_latch   <= 1'b0;
            r_disp_freeze <= 1'b0;
            r_running     <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_count_en    <= w_tick_c;
            r_count_clr   <= w_clr_c;
            r_lap_latch   <= w_lap_c;
            r_disp_freeze <= (w_next_state == ST_LAP);
            r_running     <= is_running(w_next_state);
        end
    end

    assign o_count_en    = r_count_en;
    assign o_count_clr   = r_count_clr;
    assign o_lap_latch   = r_lap_latch;
    assign o_disp_freeze = r_disp_freeze;
    assign o_running     = r_running;
    assign o_state       = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with TICK_DIV=4 and hand-derived per-cycle expectations.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ss = 1'b0;
    logic       lc = 1'b0;
    logic       tm = 1'b0;
    logic       count_en, count_clr, lap_latch, disp_freeze, running;
    logic [1:0] state;

    typedef struct {
        int         step;
        logic [1:0] st;
        logic       en;
        logic       clr;
        logic       lap;
        logic       frz;
        logic       run;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_no  = 0;

    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_LAP = 2'd2, S_PAUSE = 2'd3;

    stopwatch_ctrl #(
        .CLK_FREQ_HZ (400),
        .TICK_HZ     (100),
        .TICK_DIV    (4)
    ) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_btn_start_stop (ss),
        .i_btn_lap_clear  (lc),
        .i_time_max       (tm),
        .o_count_en       (count_en),
        .o_count_clr      (count_clr),
        .o_lap_latch      (lap_latch),
        .o_disp_freeze    (disp_freeze),
        .o_running        (running),
        .o_state          (state)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input logic a_ss, input logic a_lc, input logic a_tm, input logic a_rst,
                       input logic [1:0] est, input logic een, input logic eclr, input logic elap);
        exp_t e;
        ss = a_ss; lc = a_lc; tm = a_tm; reset = a_rst;
        @(posedge clk);
        step_no++;
        e.step = step_no;
        e.st   = est;
        e.en   = een;
        e.clr  = eclr;
        e.lap  = elap;
        e.frz  = (est == S_LAP);
        e.run  = (est == S_RUN) || (est == S_LAP);
        exp_q.push_back(e);
        #1;
    endtask

    // n quiet cycles in one state; bit k of mask is the expected count_en on cycle k.
    task automatic idle(input int n, input logic [1:0] st, input logic [31:0] mask, input logic a_tm);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, a_tm, 1'b0, st, mask[k], 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (state !== e.st || count_en !== e.en || count_clr !== e.clr || lap_latch !== e.lap ||
                disp_freeze !== e.frz || running !== e.run) begin
                n_fail++;
                $display("FAIL step%0d: got st=%0d en=%b clr=%b lap=%b frz=%b run=%b, want st=%0d en=%b clr=%b lap=%b frz=%b run=%b",
                         e.step, state, count_en, count_clr, lap_latch, disp_freeze, running,
                         e.st, e.en, e.clr, e.lap, e.frz, e.run);
            end
        end
    end

    initial begin
        // reset
        cyc(0, 0, 0, 1, S_IDLE, 0, 0, 0);
        cyc(0, 0, 0, 1, S_IDLE, 0, 0, 0);
        idle(1, S_IDLE, 32'h0, 0);
        // 1: start, ticks at 4, 8, 12
        cyc(1, 0, 0, 0, S_RUN, 0, 0, 0);
        idle(12, S_RUN, 32'h888, 0);
        // 2: stop at p==2, hold, resume finishes partial tick
        idle(2, S_RUN, 32'h0, 0);
        cyc(1, 0, 0, 0, S_PAUSE, 0, 0, 0);
        idle(20, S_PAUSE, 32'h0, 0);
        cyc(1, 0, 0, 0, S_RUN, 0, 0, 0);
        idle(2, S_RUN, 32'h2, 0);
        // 3: lap in, tick cadence kept, lap out
        cyc(0, 1, 0, 0, S_LAP, 0, 0, 1);
        idle(7, S_LAP, 32'h44, 0);
        cyc(0, 1, 0, 0, S_RUN, 0, 0, 0);
        idle(3, S_RUN, 32'h4, 0);
        // 4: simultaneous buttons, then clear from pause
        cyc(1, 1, 0, 0, S_PAUSE, 0, 0, 0);
        idle(2, S_PAUSE, 32'h0, 0);
        cyc(0, 1, 0, 0, S_IDLE, 0, 1, 0);
        idle(1, S_IDLE, 32'h0, 0);
        cyc(1, 0, 0, 0, S_RUN, 0, 0, 0);
        idle(4, S_RUN, 32'h8, 0);
        // tick coincident with stop
        idle(3, S_RUN, 32'h0, 0);
        cyc(1, 0, 0, 0, S_PAUSE, 1, 0, 0);
        cyc(1, 0, 0, 0, S_RUN, 0, 0, 0);
        idle(4, S_RUN, 32'h8, 0);
        // 5: time_max at a due tick
        idle(3, S_RUN, 32'h0, 0);
        cyc(0, 0, 1, 0, S_PAUSE, 0, 0, 0);
        cyc(1, 0, 1, 0, S_PAUSE, 0, 0, 0);
        idle(2, S_PAUSE, 32'h0, 1);
        cyc(0, 1, 1, 0, S_IDLE, 0, 1, 0);
        // 6: reset while in LAP
        cyc(1, 0, 0, 0, S_RUN, 0, 0, 0);
        cyc(0, 1, 0, 0, S_LAP, 0, 0, 1);
        idle(2, S_LAP, 32'h0, 0);
        cyc(1, 1, 0, 1, S_IDLE, 0, 0, 0);
        idle(1, S_IDLE, 32'h0, 0);
        cyc(1, 0, 0, 0, S_RUN, 0, 0, 0);
        idle(4, S_RUN, 32'h8, 0);
        // drain scoreboard
        repeat (3) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
